sc_levelsequencer: RTL and testbench

- Control FSM directly upstream of the background-type row register.
- Drives that register's transition-counter bus and its control strobes: clear, load, load-final-register and shift selection.
- Sequences the game: START → transition → level 1..4 → WIN, with a LOSE exit on lives exhausted.
- Consumes a debounced start button, a periodic tick, frog-arrival and collision pulses, and a goals-full flag.

---
 rtl/sc_levelsequencer_pkg.sv | 35 +++
 rtl/sc_tickdivider.sv | 29 ++
 rtl/sc_levelsequencer.sv | 203 ++++++++++++++++++++
 tb/tb_sc_levelsequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_levelsequencer_pkg.sv
// Shared encodings for the level sequencer and the background-type row register.
// Holds state codes, shift-selection codes and screen-index constants.
package sc_levelsequencer_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE_LOAD  = 4'd0;
  localparam state_t ST_IDLE       = 4'd1;
  localparam state_t ST_TRANS_LOAD = 4'd2;
  localparam state_t ST_TRANS_WAIT = 4'd3;
  localparam state_t ST_LEVEL_LOAD = 4'd4;
  localparam state_t ST_PLAY       = 4'd5;
  localparam state_t ST_WIN_LOAD   = 4'd6;
  localparam state_t ST_WIN        = 4'd7;
  localparam state_t ST_LOSE       = 4'd8;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  localparam logic [3:0] TC_START = 4'd0;
  localparam logic [3:0] TC_WIN   = 4'd9;

  // Even levels alternate direction: 2 and 6 scroll left, 4 and 8 scroll right.
  function automatic logic [1:0] shift_code(input logic [3:0] tc);
    logic [1:0] code;
    case (tc)
      4'd2, 4'd6: code = SHIFT_LEFT;
      4'd4, 4'd8: code = SHIFT_RIGHT;
      default:    code = SHIFT_HOLD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sc_tickdivider.sv
// Modulo-N tick counter; o_done is combinational on the N-th enabled tick.
// i_clear synchronously reloads zero and suppresses o_done in that cycle.
module sc_tickdivider #(
  parameter logic [3:0] N = 4'd8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_done
);

  logic [3:0] r_count;
  logic       w_last;

  assign w_last = (r_count == (N - 4'd1));
  assign o_done = i_tick & ~i_clear & w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 4'd0;
    end else if (i_clear) begin
      r_count <= 4'd0;
    end else if (i_tick) begin
      r_count <= w_last ? 4'd0 : (r_count + 4'd1);
    end
  end

endmodule

// File: rtl/sc_levelsequencer.sv
// Game-flow FSM driving the background row register: START, transitions, levels 1..4, WIN/LOSE.
// All outputs registered, one cycle after the deciding input; inputs are pulses, no backpressure.
module sc_levelsequencer
  import sc_levelsequencer_pkg::*;
#(
  parameter logic [3:0] TRANS_TICKS   = 4'd8,
  parameter logic [3:0] SHIFT_TICKS   = 4'd3,
  parameter logic [1:0] LIVES_INIT    = 2'd3,
  parameter logic [3:0] LAST_LEVEL_TC = 4'd8
) (
  input  logic       sc_levelsequencer_CLOCK_50,
  input  logic       sc_levelsequencer_RESET_InLow,
  input  logic       sc_levelsequencer_start_InLow,
  input  logic       sc_levelsequencer_tick_In,
  input  logic       sc_levelsequencer_frogarrived_In,
  input  logic       sc_levelsequencer_collision_In,
  input  logic       sc_levelsequencer_goalsfull_In,
  output logic [3:0] sc_levelsequencer_transitioncounter_OutBUS,
  output logic       sc_levelsequencer_clear_OutLow,
  output logic       sc_levelsequencer_load_OutLow,
  output logic       sc_levelsequencer_LoadFinalRegister_OutLow,
  output logic [1:0] sc_levelsequencer_shiftselection_Out,
  output logic [1:0] sc_levelsequencer_lives_OutBUS
);

  localparam logic [3:0] W_TC_FINAL = LAST_LEVEL_TC + 4'd1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_start_q;
  logic [3:0] r_tc;
  logic [1:0] r_lives;
  logic       r_clear_n;
  logic       r_load_n;
  logic       r_lf_n;
  logic [1:0] r_shift;

  logic [3:0] w_tc_nxt;
  logic [1:0] w_lives_nxt;
  logic       w_clear_n_nxt;
  logic       w_load_n_nxt;
  logic       w_lf_n_nxt;
  logic [1:0] w_shift_nxt;

  logic w_start_edge;
  logic w_tc_bad;
  logic w_trans_clr;
  logic w_trans_en;
  logic w_trans_done;
  logic w_shift_clr;
  logic w_shift_en;
  logic w_shift_done;

  assign w_start_edge = r_start_q & ~sc_levelsequencer_start_InLow;
  assign w_tc_bad     = (r_tc > TC_WIN);

  assign w_trans_clr = (r_state == ST_TRANS_LOAD);
  assign w_trans_en  = (r_state == ST_TRANS_WAIT) & sc_levelsequencer_tick_In;

  // A tick that coincides with any other play event is dropped, not deferred.
  assign w_shift_clr = (r_state == ST_LEVEL_LOAD);
  assign w_shift_en  = (r_state == ST_PLAY) & sc_levelsequencer_tick_In
                     & ~sc_levelsequencer_collision_In
                     & ~sc_levelsequencer_frogarrived_In
                     & ~sc_levelsequencer_goalsfull_In;

  sc_tickdivider #(.N(TRANS_TICKS)) u_trans_div (
    .i_clk   (sc_levelsequencer_CLOCK_50),
    .i_rst_n (sc_levelsequencer_RESET_InLow),
    .i_clear (w_trans_clr),
    .i_tick  (w_trans_en),
    .o_done  (w_trans_done)
  );

  sc_tickdivider #(.N(SHIFT_TICKS)) u_shift_div (
    .i_clk   (sc_levelsequencer_CLOCK_50),
    .i_rst_n (sc_levelsequencer_RESET_InLow),
    .i_clear (w_shift_clr),
    .i_tick  (w_shift_en),
    .o_done  (w_shift_done)
  );

  always_ff @(posedge sc_levelsequencer_CLOCK_50 or negedge sc_levelsequencer_RESET_InLow) begin
    if (!sc_levelsequencer_RESET_InLow) begin
      r_state <= ST_IDLE_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE_LOAD:  w_state_nxt = ST_IDLE;
      ST_IDLE:       if (w_start_edge) w_state_nxt = ST_TRANS_LOAD;
      ST_TRANS_LOAD: w_state_nxt = ST_TRANS_WAIT;
      ST_TRANS_WAIT: if (w_trans_done) w_state_nxt = ST_LEVEL_LOAD;
      ST_LEVEL_LOAD: w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (sc_levelsequencer_collision_In) begin
          w_state_nxt = (r_lives > 2'd1) ? ST_LEVEL_LOAD : ST_LOSE;
        end else if (sc_levelsequencer_frogarrived_In) begin
          w_state_nxt = ST_PLAY;
        end else if (sc_levelsequencer_goalsfull_In) begin
          w_state_nxt = (r_tc == LAST_LEVEL_TC) ? ST_WIN_LOAD : ST_TRANS_LOAD;
        end
      end
      ST_WIN_LOAD:   w_state_nxt = ST_WIN;
      ST_WIN,
      ST_LOSE:       if (w_start_edge) w_state_nxt = ST_IDLE_LOAD;
      default:       w_state_nxt = ST_IDLE_LOAD;
    endcase
    if (w_tc_bad) w_state_nxt = ST_IDLE_LOAD;
  end

  always_comb begin
    w_tc_nxt      = r_tc;
    w_lives_nxt   = r_lives;
    w_clear_n_nxt = 1'b1;
    w_load_n_nxt  = 1'b1;
    w_lf_n_nxt    = 1'b1;
    w_shift_nxt   = SHIFT_HOLD;
    case (r_state)
      ST_IDLE_LOAD: begin
        w_load_n_nxt = 1'b0;
        w_tc_nxt     = TC_START;
      end
      ST_IDLE: begin
        if (w_start_edge) begin
          w_tc_nxt    = TC_START + 4'd1;
          w_lives_nxt = LIVES_INIT;
        end
      end
      ST_TRANS_LOAD,
      ST_LEVEL_LOAD,
      ST_WIN_LOAD: w_load_n_nxt = 1'b0;
      ST_TRANS_WAIT: begin
        if (w_trans_done) w_tc_nxt = r_tc + 4'd1;
      end
      ST_PLAY: begin
        if (sc_levelsequencer_collision_In) begin
          if (r_lives > 2'd1) begin
            w_lives_nxt = r_lives - 2'd1;
          end else begin
            w_lives_nxt   = 2'd0;
            w_clear_n_nxt = 1'b0;
          end
        end else if (sc_levelsequencer_frogarrived_In) begin
          w_lf_n_nxt = 1'b0;
        end else if (sc_levelsequencer_goalsfull_In) begin
          w_tc_nxt = (r_tc == LAST_LEVEL_TC) ? W_TC_FINAL : (r_tc + 4'd1);
        end else if (w_shift_done) begin
          w_shift_nxt = shift_code(r_tc);
        end
      end
      ST_WIN,
      ST_LOSE: begin
        if (w_start_edge) begin
          w_tc_nxt    = TC_START;
          w_lives_nxt = LIVES_INIT;
        end
      end
      default: ;
    endcase
    // An out-of-range screen index aborts to a clean restart with no strobes.
    if (w_tc_bad) begin
      w_tc_nxt      = TC_START;
      w_lives_nxt   = LIVES_INIT;
      w_clear_n_nxt = 1'b1;
      w_load_n_nxt  = 1'b1;
      w_lf_n_nxt    = 1'b1;
      w_shift_nxt   = SHIFT_HOLD;
    end
  end

  always_ff @(posedge sc_levelsequencer_CLOCK_50 or negedge sc_levelsequencer_RESET_InLow) begin
    if (!sc_levelsequencer_RESET_InLow) begin
      r_start_q <= 1'b1;
      r_tc      <= TC_START;
      r_lives   <= LIVES_INIT;
      r_clear_n <= 1'b1;
      r_load_n  <= 1'b1;
      r_lf_n    <= 1'b1;
      r_shift   <= SHIFT_HOLD;
    end else begin
      r_start_q <= sc_levelsequencer_start_InLow;
      r_tc      <= w_tc_nxt;
      r_lives   <= w_lives_nxt;
      r_clear_n <= w_clear_n_nxt;
      r_load_n  <= w_load_n_nxt;
      r_lf_n    <= w_lf_n_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  assign sc_levelsequencer_transitioncounter_OutBUS = r_tc;
  assign sc_levelsequencer_clear_OutLow             = r_clear_n;
  assign sc_levelsequencer_load_OutLow              = r_load_n;
  assign sc_levelsequencer_LoadFinalRegister_OutLow = r_lf_n;
  assign sc_levelsequencer_shiftselection_Out       = r_shift;
  assign sc_levelsequencer_lives_OutBUS             = r_lives;

endmodule

// File: tb/tb_sc_levelsequencer.sv
// Scenario bench for sc_levelsequencer: randomized tick/arrival timing against a game-rule model.
module tb_sc_levelsequencer;

  localparam int TRANS = 8;
  localparam int SHIFT = 3;
  localparam int LAST  = 8;
  localparam int LIVES = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_n = 1'b1;
  logic       tick = 1'b0;
  logic       arr = 1'b0;
  logic       col = 1'b0;
  logic       gf = 1'b0;
  logic [3:0] tc;
  logic       clr_n, load_n, lf_n;
  logic [1:0] sh, lives;

  int n_checks = 0;
  int n_pass = 0;
  int n_load = 0, n_clr = 0, n_lf = 0, n_shl = 0, n_shr = 0, n_bad_sh = 0, n_multi = 0;
  int m_tc = 0;
  int m_lives = LIVES;

  always #5 clk = ~clk;

  sc_levelsequencer dut (
    .sc_levelsequencer_CLOCK_50                 (clk),
    .sc_levelsequencer_RESET_InLow              (rst_n),
    .sc_levelsequencer_start_InLow              (start_n),
    .sc_levelsequencer_tick_In                  (tick),
    .sc_levelsequencer_frogarrived_In           (arr),
    .sc_levelsequencer_collision_In             (col),
    .sc_levelsequencer_goalsfull_In             (gf),
    .sc_levelsequencer_transitioncounter_OutBUS (tc),
    .sc_levelsequencer_clear_OutLow             (clr_n),
    .sc_levelsequencer_load_OutLow              (load_n),
    .sc_levelsequencer_LoadFinalRegister_OutLow (lf_n),
    .sc_levelsequencer_shiftselection_Out       (sh),
    .sc_levelsequencer_lives_OutBUS             (lives)
  );

  // Pulse-width monitor: counts low cycles of each strobe on the falling edge.
  always @(negedge clk) begin
    if (!load_n) n_load++;
    if (!clr_n)  n_clr++;
    if (!lf_n)   n_lf++;
    if (sh == 2'b01) n_shl++;
    if (sh == 2'b10) n_shr++;
    if (sh == 2'b11) n_bad_sh++;
    if ((int'(!load_n) + int'(!clr_n) + int'(!lf_n)) > 1) n_multi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_dir(input int t);
    if (t == 2 || t == 6) return 1;
    if (t == 4 || t == 8) return 2;
    return 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick(input logic with_arr);
    tick = 1'b1;
    arr  = with_arr;
    cyc(1);
    tick = 1'b0;
    arr  = 1'b0;
  endtask

  task automatic press_start();
    start_n = 1'b0;
    cyc($urandom_range(2, 20));
    start_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (tc !== 4'd0) $display("FAIL reset_tc: got %0d want 0", tc); else n_pass++;
    n_checks++; if (lives !== 2'(LIVES)) $display("FAIL reset_lives: got %0d want %0d", lives, LIVES); else n_pass++;
    n_checks++; if ({clr_n, load_n, lf_n, sh} !== 5'b11100)
      $display("FAIL reset_strobes: got %b want 11100", {clr_n, load_n, lf_n, sh}); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (load_n !== 1'b0) $display("FAIL reset_first_load: got %b want 0", load_n); else n_pass++;
    cyc(1);
    n_checks++; if (load_n !== 1'b1) $display("FAIL reset_load_width: got %b want 1", load_n); else n_pass++;
    m_tc = 0;
    m_lives = LIVES;
  endtask

  task automatic test_start();
    int l0;
    l0 = n_load;
    start_n = 1'b0;
    cyc(20);
    start_n = 1'b1;
    cyc(2);
    m_tc = 1;
    m_lives = LIVES;
    n_checks++; if (tc !== 4'(m_tc)) $display("FAIL start_tc: got %0d want %0d", tc, m_tc); else n_pass++;
    n_checks++; if (n_load - l0 !== 1) $display("FAIL start_loads: got %0d want 1", n_load - l0); else n_pass++;
    n_checks++; if (lives !== 2'(LIVES)) $display("FAIL start_lives: got %0d want %0d", lives, LIVES); else n_pass++;
  endtask

  // Walk a transition screen; optionally inject a start press that must be ignored.
  task automatic run_transition(input bit stray);
    int l0;
    l0 = n_load;
    for (int i = 0; i < TRANS; i++) begin
      cyc($urandom_range(0, 3));
      if (stray && i == 3) begin
        start_n = 1'b0;
        cyc(2);
        start_n = 1'b1;
        cyc(1);
      end
      if (i == TRANS - 1) begin
        n_checks++; if (tc !== 4'(m_tc)) $display("FAIL trans_early: got %0d want %0d", tc, m_tc); else n_pass++;
      end
      pulse_tick(1'b0);
    end
    cyc(3);
    m_tc = m_tc + 1;
    n_checks++; if (tc !== 4'(m_tc)) $display("FAIL trans_tc: got %0d want %0d", tc, m_tc); else n_pass++;
    n_checks++; if (n_load - l0 !== 1) $display("FAIL trans_loads: got %0d want 1", n_load - l0); else n_pass++;
  endtask

  task automatic test_shift();
    int s_l, s_r, s_f, valid, arrivals, d;
    s_l = n_shl; s_r = n_shr; s_f = n_lf;
    valid = 0; arrivals = 0;
    for (int i = 0; i < 14; i++) begin
      logic a;
      cyc($urandom_range(0, 3));
      a = ($urandom_range(0, 2) == 0);
      if (a) arrivals++; else valid++;
      pulse_tick(a);
    end
    cyc(2);
    d = exp_dir(m_tc);
    n_checks++; if (n_shl - s_l !== ((d == 1) ? valid / SHIFT : 0))
      $display("FAIL shift_left_tc%0d: got %0d want %0d", m_tc, n_shl - s_l, (d == 1) ? valid / SHIFT : 0); else n_pass++;
    n_checks++; if (n_shr - s_r !== ((d == 2) ? valid / SHIFT : 0))
      $display("FAIL shift_right_tc%0d: got %0d want %0d", m_tc, n_shr - s_r, (d == 2) ? valid / SHIFT : 0); else n_pass++;
    n_checks++; if (n_lf - s_f !== arrivals)
      $display("FAIL shift_arrivals: got %0d want %0d", n_lf - s_f, arrivals); else n_pass++;
    n_checks++; if (tc !== 4'(m_tc)) $display("FAIL shift_tc: got %0d want %0d", tc, m_tc); else n_pass++;
  endtask

  task automatic test_goals_overlap();
    int f0;
    f0 = n_lf;
    gf = 1'b1; arr = 1'b1;
    cyc(1);
    gf = 1'b0; arr = 1'b0;
    cyc(2);
    n_checks++; if (tc !== 4'(m_tc)) $display("FAIL goal_overlap_tc: got %0d want %0d", tc, m_tc); else n_pass++;
    n_checks++; if (n_lf - f0 !== 1) $display("FAIL goal_overlap_lf: got %0d want 1", n_lf - f0); else n_pass++;
  endtask

  task automatic do_goal();
    int l0;
    l0 = n_load;
    gf = 1'b1;
    cyc(1);
    gf = 1'b0;
    cyc(3);
    m_tc = (m_tc == LAST) ? LAST + 1 : m_tc + 1;
    n_checks++; if (tc !== 4'(m_tc)) $display("FAIL goal_tc: got %0d want %0d", tc, m_tc); else n_pass++;
    n_checks++; if (n_load - l0 !== 1) $display("FAIL goal_loads: got %0d want 1", n_load - l0); else n_pass++;
  endtask

  task automatic test_collision();
    int l0, c0, f0, s0;
    for (int k = 0; k < LIVES; k++) begin
      l0 = n_load; c0 = n_clr; f0 = n_lf;
      col = 1'b1;
      arr = (k == 0);
      cyc(1);
      col = 1'b0; arr = 1'b0;
      cyc(4);
      m_lives = (m_lives > 1) ? m_lives - 1 : 0;
      n_checks++; if (lives !== 2'(m_lives)) $display("FAIL col_lives_%0d: got %0d want %0d", k, lives, m_lives); else n_pass++;
      n_checks++; if (tc !== 4'(m_tc)) $display("FAIL col_tc_%0d: got %0d want %0d", k, tc, m_tc); else n_pass++;
      n_checks++; if (n_load - l0 !== ((m_lives > 0) ? 1 : 0))
        $display("FAIL col_loads_%0d: got %0d want %0d", k, n_load - l0, (m_lives > 0) ? 1 : 0); else n_pass++;
      n_checks++; if (n_clr - c0 !== ((m_lives == 0) ? 1 : 0))
        $display("FAIL col_clear_%0d: got %0d want %0d", k, n_clr - c0, (m_lives == 0) ? 1 : 0); else n_pass++;
      n_checks++; if (n_lf - f0 !== 0) $display("FAIL col_lf_%0d: got %0d want 0", k, n_lf - f0); else n_pass++;
    end
    s0 = n_shl + n_shr;
    col = 1'b1; cyc(1); col = 1'b0;
    for (int i = 0; i < 6; i++) pulse_tick(1'b0);
    cyc(2);
    n_checks++; if (lives !== 2'd0) $display("FAIL lose_saturate: got %0d want 0", lives); else n_pass++;
    n_checks++; if (n_shl + n_shr - s0 !== 0) $display("FAIL lose_shifts: got %0d want 0", n_shl + n_shr - s0); else n_pass++;
    l0 = n_load;
    press_start();
    m_tc = 0; m_lives = LIVES;
    n_checks++; if (tc !== 4'd0) $display("FAIL lose_restart_tc: got %0d want 0", tc); else n_pass++;
    n_checks++; if (lives !== 2'(LIVES)) $display("FAIL lose_restart_lives: got %0d want %0d", lives, LIVES); else n_pass++;
    n_checks++; if (n_load - l0 !== 1) $display("FAIL lose_restart_load: got %0d want 1", n_load - l0); else n_pass++;
  endtask

  task automatic test_win();
    int s0;
    press_start();
    m_tc = 1; m_lives = LIVES;
    run_transition(1'b0);
    while (m_tc < LAST) begin
      do_goal();
      run_transition(1'b0);
    end
    test_shift();
    do_goal();
    s0 = n_shl + n_shr;
    for (int i = 0; i < 9; i++) begin
      cyc($urandom_range(0, 2));
      pulse_tick(1'b0);
    end
    cyc(2);
    n_checks++; if (tc !== 4'(LAST + 1)) $display("FAIL win_hold_tc: got %0d want %0d", tc, LAST + 1); else n_pass++;
    n_checks++; if (n_shl + n_shr - s0 !== 0) $display("FAIL win_shifts: got %0d want 0", n_shl + n_shr - s0); else n_pass++;
    press_start();
    m_tc = 0;
    n_checks++; if (tc !== 4'd0) $display("FAIL win_restart_tc: got %0d want 0", tc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    press_start();
    m_tc = 1; m_lives = LIVES;
    run_transition(1'b0);
    col = 1'b1; cyc(1); col = 1'b0; cyc(4);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (tc !== 4'd0) $display("FAIL midreset_tc: got %0d want 0", tc); else n_pass++;
    n_checks++; if (lives !== 2'(LIVES)) $display("FAIL midreset_lives: got %0d want %0d", lives, LIVES); else n_pass++;
    n_checks++; if ({clr_n, load_n, lf_n} !== 3'b111) $display("FAIL midreset_strobes: got %b want 111", {clr_n, load_n, lf_n}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (load_n !== 1'b0) $display("FAIL midreset_load: got %b want 0", load_n); else n_pass++;
    cyc(1);
    n_checks++; if (load_n !== 1'b1) $display("FAIL midreset_load_width: got %b want 1", load_n); else n_pass++;
  endtask

  initial begin
    #2;
    test_reset();
    test_start();
    run_transition(1'b1);
    test_shift();
    test_goals_overlap();
    do_goal();
    run_transition(1'b0);
    test_shift();
    do_goal();
    run_transition(1'b0);
    test_collision();
    test_win();
    test_reset_mid();
    n_checks++; if (n_multi !== 0) $display("FAIL strobe_exclusive: got %0d cycles want 0", n_multi); else n_pass++;
    n_checks++; if (n_bad_sh !== 0) $display("FAIL shift_code_11: got %0d cycles want 0", n_bad_sh); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
